// File: rtl/frac_clk_gen.sv
// Multi-channel fractional clock-enable generator: each channel's phase accumulator
// produces a one-cycle ce strobe, a square wave (accumulator MSB) and a sticky lock flag.
module frac_clk_gen #(
  parameter int CH_NUM   = 3,
  parameter int ACC_W    = 32,
  parameter int LOCK_CNT = 10,
  parameter logic [CH_NUM*ACC_W-1:0] INIT_INC = {CH_NUM{{1'b1, {(ACC_W-1){1'b0}}}}},
  localparam int CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic [CH_NUM-1:0] ce,
  output logic [CH_NUM-1:0] clk_out,
  output logic [CH_NUM-1:0] locked,
  output logic              all_locked
);

  localparam int CNT_W = $clog2(LOCK_CNT + 1);

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    logic [ACC_W-1:0] inc_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ce_q;
    logic             clk_q;
    logic             lock_q;
    logic [ACC_W:0]   sum;
    logic             wr_hit;

    // Carry out of the accumulator is the ce strobe; out-of-range cfg_ch matches no channel.
    assign sum    = {1'b0, acc_q} + {1'b0, inc_q};
    assign wr_hit = cfg_wr && (int'(cfg_ch) == i);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        inc_q  <= INIT_INC[i*ACC_W +: ACC_W];
        acc_q  <= '0;
        cnt_q  <= '0;
        ce_q   <= 1'b0;
        clk_q  <= 1'b0;
        lock_q <= 1'b0;
      end else if (wr_hit) begin
        // A write always restarts the channel, even with an unchanged increment.
        inc_q  <= cfg_inc;
        acc_q  <= '0;
        cnt_q  <= '0;
        ce_q   <= 1'b0;
        clk_q  <= 1'b0;
        lock_q <= 1'b0;
      end else begin
        acc_q <= sum[ACC_W-1:0];
        ce_q  <= sum[ACC_W];
        clk_q <= sum[ACC_W-1];
        if (ce_q && !lock_q) begin
          if (cnt_q != CNT_W'(LOCK_CNT)) begin
            cnt_q <= cnt_q + 1'b1;
          end
          if (cnt_q == CNT_W'(LOCK_CNT - 1)) begin
            lock_q <= 1'b1;
          end
        end
      end
    end

    assign ce[i]      = ce_q;
    assign clk_out[i] = clk_q;
    assign locked[i]  = lock_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      all_locked <= 1'b0;
    end else begin
      all_locked <= &locked;
    end
  end

endmodule

// File: tb/tb_frac_clk_gen.sv
// Directed bench for frac_clk_gen with ACC_W=8, LOCK_CNT=10, three channels at 0x80 after reset.
module tb_frac_clk_gen;
  localparam int CH_NUM   = 3;
  localparam int ACC_W    = 8;
  localparam int LOCK_CNT = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [1:0] cfg_ch = 2'd0;
  logic [7:0] cfg_inc = 8'd0;
  logic [2:0] ce;
  logic [2:0] clk_out;
  logic [2:0] locked;
  logic       all_locked;

  int err_cnt = 0;
  int chk_cnt = 0;
  int edge_n  = 0;
  int base[3];
  int inc_m[3];
  logic [31:0] exp_q[$];

  frac_clk_gen #(
    .CH_NUM(CH_NUM), .ACC_W(ACC_W), .LOCK_CNT(LOCK_CNT), .INIT_INC({3{8'h80}})
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_inc(cfg_inc),
    .ce(ce), .clk_out(clk_out), .locked(locked), .all_locked(all_locked)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  // Expected {ce, clk_out} k edges after a restart with increment inc (ideal arithmetic).
  function automatic logic [1:0] model(input int inc, input int k);
    longint a;
    longint b;
    if (k <= 0) return 2'b00;
    a = longint'(inc) * k;
    b = longint'(inc) * (k - 1);
    return {((a >> 8) != (b >> 8)), a[7]};
  endfunction

  task automatic model_cmp(inout int bad);
    logic [1:0] m;
    for (int i = 0; i < CH_NUM; i++) begin
      m = model(inc_m[i], edge_n - base[i]);
      if (ce[i] !== m[1] || clk_out[i] !== m[0]) bad++;
    end
  endtask

  task automatic write_cfg(input int ch, input int inc);
    cfg_wr  = 1'b1;
    cfg_ch  = ch[1:0];
    cfg_inc = inc[7:0];
    tick();
    cfg_wr  = 1'b0;
    if (ch < CH_NUM) begin
      base[ch]  = edge_n;
      inc_m[ch] = inc;
    end
  endtask

  // Called with rst_n low, away from a clock edge.
  task automatic reset_seq();
    check("rst_ce", 32'(ce), 32'd0);
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_all_locked", 32'(all_locked), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    edge_n = 0;
    for (int i = 0; i < CH_NUM; i++) begin
      base[i]  = 0;
      inc_m[i] = 8'h80;
    end
    for (int k = 1; k <= 22; k++) begin
      tick();
      check("seq_ce", 32'(ce), (k % 2 == 0) ? 32'd7 : 32'd0);
      check("seq_clk_out", 32'(clk_out), (k % 2 == 1) ? 32'd7 : 32'd0);
      check("seq_locked", 32'(locked), (k >= 21) ? 32'd7 : 32'd0);
      check("seq_all_locked", 32'(all_locked), (k >= 22) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int bad;
    int gap_bad;
    int n_pulse;
    int last_k;
    int k;
    logic [31:0] exp_k;

    #12;
    reset_seq();

    // Channel 1 at 0x55: 85 pulses in 256 cycles, spacing 3 or 4.
    write_cfg(1, 8'h55);
    check("wr1_locked", 32'(locked), 32'd5);
    check("wr1_ce", 32'(ce[1]), 32'd0);
    exp_q.delete();
    for (int j = 1; j <= 256; j++) begin
      if (model(8'h55, j) >= 2'b10) exp_q.push_back(32'(j));
    end
    bad = 0; gap_bad = 0; n_pulse = 0; last_k = 0;
    for (int j = 1; j <= 256; j++) begin
      tick();
      k = edge_n - base[1];
      model_cmp(bad);
      if (locked[0] !== 1'b1 || locked[2] !== 1'b1) bad++;
      if (ce[1]) begin
        n_pulse++;
        if (last_k > 0 && (k - last_k < 3 || k - last_k > 4)) gap_bad++;
        last_k = k;
        if (exp_q.size() == 0) begin
          check("ch1_extra_pulse", 32'(k), 32'd0);
        end else begin
          exp_k = exp_q.pop_front();
          check("ch1_pulse_pos", 32'(k), exp_k);
        end
      end
    end
    check("ch1_pulses", 32'(n_pulse), 32'd85);
    check("ch1_queue_left", 32'(exp_q.size()), 32'd0);
    check("ch1_spacing", 32'(gap_bad), 32'd0);
    check("ch1_disturb", 32'(bad), 32'd0);
    check("ch1_locked_end", 32'(locked), 32'd7);
    check("ch1_all_locked_end", 32'(all_locked), 32'd1);

    // Stop channel 2 while locked.
    write_cfg(2, 0);
    check("stop2_locked", 32'(locked), 32'd3);
    check("stop2_all_locked_t", 32'(all_locked), 32'd1);
    tick();
    check("stop2_all_locked_t1", 32'(all_locked), 32'd0);
    bad = 0;
    for (int j = 0; j < 1000; j++) begin
      tick();
      if (ce[2] | clk_out[2] | locked[2]) bad++;
      model_cmp(bad);
    end
    check("stop2_quiet", 32'(bad), 32'd0);

    // Out-of-range channel: nothing changes.
    write_cfg(3, 8'hAA);
    bad = 0;
    model_cmp(bad);
    for (int j = 0; j < 100; j++) begin
      tick();
      model_cmp(bad);
      if (locked !== 3'b011 || all_locked !== 1'b0) bad++;
    end
    check("bad_ch_ignored", 32'(bad), 32'd0);

    // Same-value rewrite of channel 0 on an odd edge realigns the ce phase.
    if (edge_n % 2 == 1) tick();
    write_cfg(0, 8'h80);
    check("rw0_ce_t", 32'(ce[0]), 32'd0);
    check("rw0_clk_t", 32'(clk_out[0]), 32'd0);
    check("rw0_locked_t", 32'(locked[0]), 32'd0);
    tick();
    check("rw0_ce_t1", 32'(ce[0]), 32'd0);
    check("rw0_clk_t1", 32'(clk_out[0]), 32'd1);
    tick();
    check("rw0_ce_t2", 32'(ce[0]), 32'd1);
    bad = 0;
    for (int j = 3; j <= 21; j++) begin
      tick();
      model_cmp(bad);
      if (j == 20) check("rw0_locked_t20", 32'(locked[0]), 32'd0);
      if (j == 21) check("rw0_locked_t21", 32'(locked[0]), 32'd1);
    end
    check("rw0_phase", 32'(bad), 32'd0);

    // Asynchronous reset mid-cycle while locked, then the power-up sequence repeats.
    check("pre_rst_locked", 32'(locked), 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    reset_seq();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
